// File: rtl/nnet_pkg.sv
// rtl/nnet_pkg.sv - shared FSM encoding, width defaults and tail-word layout for the result framer
// Optional argmax tail word: NNET_FRAMER_ARGMAX_EN
package nnet_pkg;

  localparam int IN_W_DEF   = 16;
  localparam int OUT_W_DEF  = 32;
  localparam int LEN_W      = 16;
  // Tail word: index in the top TAIL_IDX_W bits, max value in the bits below
  localparam int TAIL_IDX_W = 16;

`ifdef NNET_FRAMER_ARGMAX_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/nnet_argmax.sv
// rtl/nnet_argmax.sv - per-frame running maximum (signed, earliest index wins ties)
// Only instantiated when NNET_FRAMER_ARGMAX_EN is defined
module nnet_argmax
  import nnet_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic [IN_W-1:0]       i_sample,
  input  logic                  i_accept,
  input  logic                  i_frame_start,
  output logic [IN_W-1:0]       o_max,
  output logic [TAIL_IDX_W-1:0] o_index
);

  logic [IN_W-1:0]       r_max;
  logic [TAIL_IDX_W-1:0] r_idx;
  logic [TAIL_IDX_W-1:0] r_pos;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_max <= '0;
      r_idx <= '0;
      r_pos <= '0;
    end else if (i_accept) begin
      if (i_frame_start) begin
        r_max <= i_sample;
        r_idx <= '0;
        r_pos <= TAIL_IDX_W'(1);
      end else begin
        if ($signed(i_sample) > $signed(r_max)) begin
          r_max <= i_sample;
          r_idx <= r_pos;
        end
        r_pos <= r_pos + TAIL_IDX_W'(1);
      end
    end
  end

  assign o_max   = r_max;
  assign o_index = r_idx;

endmodule

// File: rtl/nnet_result_framer.sv
// rtl/nnet_result_framer.sv - frames HLS result samples into tlast-delimited output words
// NNET_FRAMER_ARGMAX_EN appends an {index, max} tail word to every frame
module nnet_result_framer
  import nnet_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [15:0]      frame_len,
  input  logic [IN_W-1:0]  s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [31:0]      frame_cnt,
  output logic             len_err
);

`ifdef NNET_FRAMER_ARGMAX_EN
  localparam state_t ST_AFTER_LAST = ST_TAIL;
  localparam logic   DATA_TLAST_EN = 1'b0;
`else
  localparam state_t ST_AFTER_LAST = ST_IDLE;
  localparam logic   DATA_TLAST_EN = 1'b1;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_m_tdata;
  logic             r_m_tvalid;
  logic             r_m_tlast;
  logic [31:0]      r_frame_cnt;
  logic             r_len_err;

  logic             w_out_free;
  logic             w_accept;
  logic             w_frame_start;
  logic             w_is_last;
  logic             w_tail_load;
  logic [LEN_W-1:0] w_len_eff;
  logic [OUT_W-1:0] w_sample_ext;
  logic [OUT_W-1:0] w_tail_word;

  assign w_out_free = !r_m_tvalid || m_tready;
`ifdef NNET_FRAMER_ARGMAX_EN
  assign s_tready = reset_n && (r_state != ST_TAIL) && w_out_free;
`else
  assign s_tready = reset_n && w_out_free;
`endif
  assign w_accept      = s_tvalid && s_tready;
  assign w_frame_start = w_accept && (r_state == ST_IDLE);
  // A zero length is served as single-sample frames
  assign w_len_eff = (r_state != ST_IDLE) ? r_len :
                     (frame_len == '0) ? LEN_W'(1) : frame_len;
  assign w_is_last = (r_cnt == w_len_eff - LEN_W'(1));

  always_comb begin
    w_sample_ext = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_sample_ext[i] = s_tdata[(i < IN_W) ? i : IN_W - 1];
    end
  end

`ifdef NNET_FRAMER_ARGMAX_EN
  logic [IN_W-1:0]       w_am_max;
  logic [TAIL_IDX_W-1:0] w_am_index;
  logic                  r_tail_loaded;

  nnet_argmax #(.IN_W(IN_W)) u_argmax (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clear       (clear),
    .i_sample      (s_tdata),
    .i_accept      (w_accept),
    .i_frame_start (w_frame_start),
    .o_max         (w_am_max),
    .o_index       (w_am_index)
  );

  always_comb begin
    w_tail_word = '0;
    w_tail_word[OUT_W-1 -: TAIL_IDX_W] = w_am_index;
    for (int i = 0; i < OUT_W - TAIL_IDX_W; i++) begin
      w_tail_word[i] = w_am_max[(i < IN_W) ? i : IN_W - 1];
    end
  end

  // The tail waits until the final data word has left the output register
  assign w_tail_load = (r_state == ST_TAIL) && !r_tail_loaded && w_out_free;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_tail_loaded <= 1'b0;
    end else if (w_tail_load) begin
      r_tail_loaded <= 1'b1;
    end else if (r_state == ST_TAIL && r_m_tvalid && m_tready) begin
      r_tail_loaded <= 1'b0;
    end
  end
`else
  assign w_tail_word = '0;
  assign w_tail_load = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_is_last ? ST_AFTER_LAST : ST_DATA;
      ST_DATA: if (w_accept && w_is_last) w_state_nxt = ST_AFTER_LAST;
`ifdef NNET_FRAMER_ARGMAX_EN
      ST_TAIL: if (r_tail_loaded && r_m_tvalid && m_tready) w_state_nxt = ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_m_tdata   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_frame_cnt <= '0;
      r_len_err   <= 1'b0;
    end else if (clear) begin
      r_cnt       <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_frame_cnt <= '0;
      r_len_err   <= 1'b0;
    end else begin
      if (r_m_tvalid && m_tready && r_m_tlast) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
      if (w_accept) begin
        r_m_tdata  <= w_sample_ext;
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= DATA_TLAST_EN && w_is_last;
        r_cnt      <= w_is_last ? '0 : r_cnt + LEN_W'(1);
        if (w_frame_start) begin
          r_len <= w_len_eff;
          if (frame_len == '0) r_len_err <= 1'b1;
        end
      end else if (w_tail_load) begin
        r_m_tdata  <= w_tail_word;
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= 1'b1;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_tdata   = r_m_tdata;
  assign m_tvalid  = r_m_tvalid;
  assign m_tlast   = r_m_tlast;
  assign frame_cnt = r_frame_cnt;
  assign len_err   = r_len_err;

endmodule

// File: tb/tb_nnet_result_framer.sv
// tb/tb_nnet_result_framer.sv - directed self-checking bench for nnet_result_framer
// NNET_FRAMER_ARGMAX_EN selects the argmax tail-word scenario
`timescale 1ns/1ps
module tb_nnet_result_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [15:0] frame_len;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] frame_cnt;
  logic        len_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] tx_q[$];
  logic [32:0] rx_q[$];
  logic [32:0] exp_q[$];
  int          sw_at = 0;
  logic [15:0] sw_len = 16'd0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = 33'd0;

  always #5 clk = ~clk;

  nnet_result_framer #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .frame_len (frame_len),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .frame_cnt (frame_cnt),
    .len_err   (len_err)
  );

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output words are logged as {tlast, tdata} at the negedge before their handshake edge
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", 33'(m_tvalid), 33'd1);
      check("stall_word", {m_tlast, m_tdata}, prev_word);
    end
    if (reset_n && !clear && m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
    prev_stall = reset_n && !clear && m_tvalid && !m_tready;
    prev_word  = {m_tlast, m_tdata};
  end

  task automatic run_tx(input int n_words, input bit toggle);
    int  cyc = 0;
    int  acc = 0;
    bit  accepted;
    while ((tx_q.size() > 0 || rx_q.size() < n_words) && cyc < 300) begin
      if (tx_q.size() > 0) begin
        s_tvalid = 1'b1;
        s_tdata  = tx_q[0];
      end else begin
        s_tvalid = 1'b0;
      end
      m_tready = toggle ? ~m_tready : 1'b1;
      @(negedge clk);
      accepted = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (accepted) begin
        void'(tx_q.pop_front());
        acc++;
        if (acc == sw_at) frame_len = sw_len;
      end
      cyc++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    check("run_in_budget", 33'(cyc < 300), 33'd1);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, 33'(rx_q.size()), 33'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    frame_len = 16'd4;
    s_tdata   = 16'h0005;
    s_tvalid  = 1'b1;
    m_tready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 33'(s_tready), 33'd0);
    check("rst_m_tvalid", 33'(m_tvalid), 33'd0);
    check("rst_m_tlast", 33'(m_tlast), 33'd0);
    check("rst_m_tdata", 33'(m_tdata), 33'd0);
    check("rst_frame_cnt", 33'(frame_cnt), 33'd0);
    check("rst_len_err", 33'(len_err), 33'd0);
    s_tvalid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_tready", 33'(s_tready), 33'd1);

`ifdef NNET_FRAMER_ARGMAX_EN
    frame_len = 16'd4;
    rx_q.delete();
    tx_q  = '{16'h0005, 16'h0009, 16'h0009, 16'hFFFF};
    run_tx(5, 1'b0);
    exp_q = '{33'h0_00000005, 33'h0_00000009, 33'h0_00000009, 33'h0_FFFFFFFF, 33'h1_00010009};
    check_rx("argmax");
    check("argmax_frame_cnt", 33'(frame_cnt), 33'd1);
`else
    frame_len = 16'd4;
    rx_q.delete();
    tx_q  = '{16'h0001, 16'hFFFE, 16'h0003, 16'h0004};
    run_tx(4, 1'b0);
    exp_q = '{33'h0_00000001, 33'h0_FFFFFFFE, 33'h0_00000003, 33'h1_00000004};
    check_rx("basic");
    check("basic_frame_cnt", 33'(frame_cnt), 33'd1);
    check("basic_len_err", 33'(len_err), 33'd0);

    frame_len = 16'd3;
    rx_q.delete();
    tx_q  = '{16'h0064, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h1234};
    run_tx(6, 1'b1);
    exp_q = '{33'h0_00000064, 33'h0_FFFF8000, 33'h1_00007FFF,
              33'h0_FFFFFFFF, 33'h0_00000005, 33'h1_00001234};
    check_rx("stall");
    check("stall_frame_cnt", 33'(frame_cnt), 33'd3);

    frame_len = 16'd0;
    rx_q.delete();
    tx_q  = '{16'h0007, 16'h0008, 16'h0009};
    run_tx(3, 1'b0);
    exp_q = '{33'h1_00000007, 33'h1_00000008, 33'h1_00000009};
    check_rx("len0");
    check("len0_frame_cnt", 33'(frame_cnt), 33'd6);
    check("len0_len_err", 33'(len_err), 33'd1);

    frame_len = 16'd4;
    sw_at  = 2;
    sw_len = 16'd2;
    rx_q.delete();
    tx_q  = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016};
    run_tx(6, 1'b0);
    sw_at = 0;
    exp_q = '{33'h0_00000011, 33'h0_00000012, 33'h0_00000013, 33'h1_00000014,
              33'h0_00000015, 33'h1_00000016};
    check_rx("lenchg");
    check("lenchg_frame_cnt", 33'(frame_cnt), 33'd8);

    frame_len = 16'd4;
    m_tready  = 1'b1;
    s_tvalid  = 1'b1;
    s_tdata   = 16'h000A;
    @(posedge clk);
    #1;
    s_tdata = 16'h000B;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    check("clr_pre_valid", 33'(m_tvalid), 33'd1);
    check("clr_pre_data", 33'(m_tdata), 33'h0000000B);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_m_tvalid", 33'(m_tvalid), 33'd0);
    check("clr_m_tlast", 33'(m_tlast), 33'd0);
    check("clr_frame_cnt", 33'(frame_cnt), 33'd0);
    check("clr_len_err", 33'(len_err), 33'd0);
    m_tready = 1'b1;
    rx_q.delete();
    tx_q  = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
    run_tx(4, 1'b0);
    exp_q = '{33'h0_00000020, 33'h0_00000021, 33'h0_00000022, 33'h1_00000023};
    check_rx("postclr");
    check("postclr_frame_cnt", 33'(frame_cnt), 33'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
